object_placer: RTL and testbench

Setup-phase placement sequencer that drives the `SET`/`SETUP_PHASE`/`in_x`/`in_y` load interface of the static world objects (nest, food sources). After `START`, it generates pseudo-random candidate positions from an LFSR and rejects any candidate outside the play-field margins. It probes each in-range candidate against already-placed objects through their collision outputs, then commits each free candidate to one object with a `SET`/`LD` handshake. It sits between the top-level setup control and the object array, and owns `SETUP_PHASE`.

---
 rtl/object_placer.sv | 154 +++++++++++++++
 tb/tb_object_placer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/object_placer.sv
// Setup-phase placement sequencer: LFSR candidates, margin filter,
// collision probe and SET/LD commit for each static world object.
module object_placer #(
   parameter int          X_bits    = 10,
   parameter int          Y_bits    = 9,
   parameter int          N_OBJ     = 4,
   parameter int          X_MAX     = 639,
   parameter int          Y_MAX     = 479,
   parameter int          MARGIN    = 16,
   parameter logic [15:0] SEED      = 16'hACE1,
   parameter int          MAX_TRIES = 64,
   parameter int          OS_bits   = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
   input  logic               setup_clk,
   input  logic               RESET,
   input  logic               START,
   input  logic               collision,
   input  logic               LD,
   output logic               SETUP_PHASE,
   output logic               SET,
   output logic [OS_bits-1:0] obj_sel,
   output logic [X_bits-1:0]  out_x,
   output logic [Y_bits-1:0]  out_y,
   output logic [X_bits-1:0]  collide_x,
   output logic [Y_bits-1:0]  collide_y,
   output logic               DONE,
   output logic               FAIL
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GEN,
      S_PROBE,
      S_CHECK,
      S_COMMIT,
      S_DONE,
      S_FAIL
   } state_t;

   localparam logic [OS_bits-1:0] LAST = OS_bits'(N_OBJ - 1);
   localparam logic [7:0]         TMAX = 8'(MAX_TRIES);

   state_t               state_q, state_d;
   logic [15:0]          lfsr_q, lfsr_d;
   logic [X_bits-1:0]    cand_x_q, cand_x_d;
   logic [Y_bits-1:0]    cand_y_q, cand_y_d;
   logic [OS_bits-1:0]   obj_sel_q, obj_sel_d;
   logic [7:0]           tries_q, tries_d;
   logic                 coll_q, coll_d;

   logic [15:0]          lfsr_nx;
   logic [X_bits-1:0]    nx;
   logic [Y_bits-1:0]    ny;
   logic [7:0]           tries_nx;
   logic                 hit;
   logic                 legal;

   assign lfsr_nx  = {lfsr_q[14:0],
                      lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign nx       = lfsr_nx[X_bits-1:0];
   assign ny       = lfsr_nx[15:16-Y_bits];
   assign tries_nx = tries_q + 8'd1;
   assign hit      = (tries_nx >= TMAX);

   // Signed int compares keep an empty range (MARGIN too big) empty.
   assign legal = (int'(nx) >= MARGIN) && (int'(nx) <= X_MAX - MARGIN) &&
                  (int'(ny) >= MARGIN) && (int'(ny) <= Y_MAX - MARGIN);

   always_ff @(posedge setup_clk or posedge RESET) begin
      if (RESET) begin
         state_q   <= S_IDLE;
         lfsr_q    <= SEED;
         cand_x_q  <= '0;
         cand_y_q  <= '0;
         obj_sel_q <= '0;
         tries_q   <= '0;
         coll_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         cand_x_q  <= cand_x_d;
         cand_y_q  <= cand_y_d;
         obj_sel_q <= obj_sel_d;
         tries_q   <= tries_d;
         coll_q    <= coll_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      lfsr_d    = lfsr_q;
      cand_x_d  = cand_x_q;
      cand_y_d  = cand_y_q;
      obj_sel_d = obj_sel_q;
      tries_d   = tries_q;
      coll_d    = coll_q;
      unique case (state_q)
         S_IDLE, S_DONE, S_FAIL: begin
            if (START) begin
               state_d   = S_GEN;
               obj_sel_d = '0;
               tries_d   = '0;
            end
         end
         S_GEN: begin
            lfsr_d   = lfsr_nx;
            cand_x_d = nx;
            cand_y_d = ny;
            if (legal) begin
               state_d = S_PROBE;
            end else begin
               tries_d = hit ? TMAX : tries_nx;
               state_d = hit ? S_FAIL : S_GEN;
            end
         end
         S_PROBE: begin
            coll_d  = collision;
            state_d = S_CHECK;
         end
         S_CHECK: begin
            if (coll_q) begin
               tries_d = hit ? TMAX : tries_nx;
               state_d = hit ? S_FAIL : S_GEN;
            end else begin
               state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            if (LD) begin
               if (obj_sel_q == LAST) begin
                  state_d = S_DONE;
               end else begin
                  obj_sel_d = obj_sel_q + OS_bits'(1);
                  tries_d   = '0;
                  state_d   = S_GEN;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign SET         = (state_q == S_COMMIT);
   assign SETUP_PHASE = (state_q == S_GEN) || (state_q == S_PROBE) ||
                        (state_q == S_CHECK) || (state_q == S_COMMIT);
   assign DONE        = (state_q == S_DONE);
   assign FAIL        = (state_q == S_FAIL);
   assign obj_sel     = obj_sel_q;
   assign out_x       = cand_x_q;
   assign out_y       = cand_y_q;
   assign collide_x   = cand_x_q;
   assign collide_y   = cand_y_q;

endmodule

// File: tb/tb_object_placer.sv
// Directed bench for object_placer: clean run, collisions, delayed
// acknowledge, range rejection, try limit and reset mid-commit.
module tb_object_placer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [3:0] st;
   int         checks = 0;
   int         errors = 0;

   logic       sp0, set0, done0, fail0, coll0, ld0, ld_man, ld_auto, cm_en;
   logic [1:0] sel0;
   logic [9:0] ox0, cx0, px1, px2;
   logic [8:0] oy0, cy0, py1, py2;

   logic       sp1, set1, done1, fail1, sel1;
   logic [3:0] ox1, cx1;
   logic [8:0] oy1, cy1;

   logic       sp2, set2, done2, fail2, sel2;
   logic [3:0] ox2, cx2;
   logic [8:0] oy2, cy2;

   logic       sp3, set3, done3, fail3, sel3, coll3;
   logic [9:0] ox3, cx3;
   logic [8:0] oy3, cy3;

   assign ld0   = ld_auto ? set0 : ld_man;
   assign coll0 = cm_en && ((cx0 == px1 && cy0 == py1) ||
                            (cx0 == px2 && cy0 == py2));

   object_placer #(.N_OBJ(3), .X_MAX(1023), .Y_MAX(511), .MARGIN(0))
   u0 (.setup_clk(clk), .RESET(rst), .START(st[0]), .collision(coll0),
       .LD(ld0), .SETUP_PHASE(sp0), .SET(set0), .obj_sel(sel0),
       .out_x(ox0), .out_y(oy0), .collide_x(cx0), .collide_y(cy0),
       .DONE(done0), .FAIL(fail0));

   object_placer #(.X_bits(4), .N_OBJ(2), .X_MAX(7), .Y_MAX(511),
                   .MARGIN(1))
   u1 (.setup_clk(clk), .RESET(rst), .START(st[1]), .collision(1'b0),
       .LD(set1), .SETUP_PHASE(sp1), .SET(set1), .obj_sel(sel1),
       .out_x(ox1), .out_y(oy1), .collide_x(cx1), .collide_y(cy1),
       .DONE(done1), .FAIL(fail1));

   object_placer #(.X_bits(4), .N_OBJ(1), .X_MAX(7), .Y_MAX(511),
                   .MARGIN(4), .MAX_TRIES(5))
   u2 (.setup_clk(clk), .RESET(rst), .START(st[2]), .collision(1'b0),
       .LD(set2), .SETUP_PHASE(sp2), .SET(set2), .obj_sel(sel2),
       .out_x(ox2), .out_y(oy2), .collide_x(cx2), .collide_y(cy2),
       .DONE(done2), .FAIL(fail2));

   object_placer #(.N_OBJ(1), .X_MAX(1023), .Y_MAX(511), .MARGIN(0),
                   .MAX_TRIES(5))
   u3 (.setup_clk(clk), .RESET(rst), .START(st[3]), .collision(coll3),
       .LD(set3), .SETUP_PHASE(sp3), .SET(set3), .obj_sel(sel3),
       .out_x(ox3), .out_y(oy3), .collide_x(cx3), .collide_y(cy3),
       .DONE(done3), .FAIL(fail3));

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   function automatic bit legal1(input logic [15:0] s);
      int x, y;
      x = int'(s[3:0]);
      y = int'(s[15:7]);
      return (x >= 1) && (x <= 6) && (y >= 1) && (y <= 510);
   endfunction

   task automatic pulse(input int w);
      @(negedge clk);
      st[w] = 1'b1;
      @(posedge clk);
      #1 st[w] = 1'b0;
   endtask

   logic [15:0] m;

   task automatic clean_run(input bit hand);
      bit es;
      pulse(0);
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         es = (k % 4 == 0) && (k <= 12);
         chk("cr_set", 32'(set0), 32'(es));
         if (es) begin
            m = step(m);
            chk("cr_sel", 32'(sel0), k / 4 - 1);
            chk("cr_x", 32'(ox0), 32'(m[9:0]));
            chk("cr_y", 32'(oy0), 32'(m[15:7]));
            if (hand && k == 4) begin
               chk("cr_x_hand", 32'(ox0), 32'd451);
               chk("cr_y_hand", 32'(oy0), 32'd179);
            end
         end
         if (k >= 13) begin
            chk("cr_done", 32'(done0), 32'd1);
            chk("cr_sp", 32'(sp0), 32'd0);
         end
      end
   endtask

   task automatic wait_set0(output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!set0 && k < 40);
   endtask

   task automatic wait_done0();
      int k = 0;
      while (!done0 && k < 80) begin
         @(negedge clk);
         k++;
      end
      chk("done_wait", 32'(done0), 32'd1);
   endtask

   initial begin
      logic [15:0] p1, p2, m3, mr;
      int          k, n, c_exp, cyc;
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] p1, p2, m3, mr;
      int          k, n, c_exp, cyc;
      rst = 1'b1; st = '0; ld_man = 1'b0; ld_auto = 1'b1;
      cm_en = 1'b0; coll3 = 1'b0;
      px1 = '0; px2 = '0; py1 = '0; py2 = '0;
      #12;
      chk("rst_set", 32'(set0), 0);
      chk("rst_sp", 32'(sp0), 0);
      chk("rst_done", 32'(done0), 0);
      chk("rst_fail", 32'(fail0), 0);
      chk("rst_sel", 32'(sel0), 0);
      chk("rst_x", 32'(ox0), 0);
      chk("rst_y", 32'(oy0), 0);
      @(negedge clk);
      rst = 1'b0;

      m = 16'hACE1;
      clean_run(1'b1);

      // delayed acknowledge: LD high in the fourth SET cycle
      ld_auto = 1'b0;
      pulse(0);
      wait_set0(k);
      chk("da_cyc", k, 4);
      m = step(m);
      for (int j = 0; j <= 3; j++) begin
         if (j > 0) @(negedge clk);
         chk("da_set", 32'(set0), 1);
         chk("da_x", 32'(ox0), 32'(m[9:0]));
         chk("da_y", 32'(oy0), 32'(m[15:7]));
         chk("da_sel", 32'(sel0), 0);
      end
      ld_man = 1'b1;
      @(negedge clk);
      ld_man = 1'b0;
      chk("da_set_low", 32'(set0), 0);
      chk("da_sp", 32'(sp0), 1);
      chk("da_sel_nx", 32'(sel0), 1);
      @(negedge clk);
      m = step(m);
      chk("da_gen_x", 32'(ox0), 32'(m[9:0]));
      ld_auto = 1'b1;
      wait_done0();
      m = step(m);

      // partial collision: first two probes hit
      p1 = step(m); p2 = step(p1); m3 = step(p2);
      px1 = p1[9:0]; py1 = p1[15:7];
      px2 = p2[9:0]; py2 = p2[15:7];
      cm_en = 1'b1;
      pulse(0);
      for (k = 1; k <= 11; k++) begin
         @(negedge clk);
         chk("pc_set", 32'(set0), 32'(k == 10));
         if (k == 10) begin
            chk("pc_x", 32'(ox0), 32'(m3[9:0]));
            chk("pc_sel", 32'(sel0), 0);
            chk("pc_tries", 32'(u0.tries_q), 2);
         end
         if (k == 11) begin
            chk("pc_tries0", 32'(u0.tries_q), 0);
            chk("pc_sel1", 32'(sel0), 1);
         end
      end
      wait_done0();
      cm_en = 1'b0;
      m = step(step(m3));

      // always colliding, then restart cleanly (N_OBJ=1)
      coll3 = 1'b1;
      pulse(3);
      for (k = 1; k <= 16; k++) begin
         @(negedge clk);
         chk("ac_set", 32'(set3), 0);
         if (k == 15) begin
            chk("ac_fail15", 32'(fail3), 0);
            chk("ac_sp15", 32'(sp3), 1);
         end
         if (k == 16) begin
            chk("ac_fail", 32'(fail3), 1);
            chk("ac_sp", 32'(sp3), 0);
         end
      end
      coll3 = 1'b0;
      pulse(3);
      for (k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk("rs_set", 32'(set3), 32'(k == 4));
         if (k == 1) begin
            chk("rs_fail", 32'(fail3), 0);
            chk("rs_sp", 32'(sp3), 1);
            chk("rs_sel", 32'(sel3), 0);
         end
         if (k == 5) begin
            chk("rs_done", 32'(done3), 1);
            chk("rs_sp5", 32'(sp3), 0);
         end
      end

      // range rejection: GEN repeats without PROBE
      mr = 16'hACE1;
      c_exp = 0;
      cyc = 0;
      pulse(1);
      for (int o = 0; o < 2; o++) begin
         n = 0;
         do begin
            mr = step(mr);
            n++;
         end while (!legal1(mr) && n < 64);
         c_exp = c_exp + n + 3;
         while (cyc < c_exp - 1) begin
            @(negedge clk);
            cyc++;
         end
         chk("rr_pre", 32'(set1), 0);
         @(negedge clk);
         cyc++;
         chk("rr_set", 32'(set1), 1);
         chk("rr_x", 32'(ox1), 32'(mr[3:0]));
         chk("rr_y", 32'(oy1), 32'(mr[15:7]));
         chk("rr_rng", 32'(ox1 >= 4'd1 && ox1 <= 4'd6), 1);
      end
      @(negedge clk);
      chk("rr_done", 32'(done1), 1);

      // empty legal range ends in FAIL after MAX_TRIES GEN cycles
      pulse(2);
      for (k = 1; k <= 6; k++) begin
         @(negedge clk);
         chk("er_set", 32'(set2), 0);
         chk("er_fail", 32'(fail2), 32'(k == 6));
         chk("er_sp", 32'(sp2), 32'(k != 6));
      end

      // reset mid-COMMIT, then the clean sequence repeats
      ld_auto = 1'b0;
      ld_man = 1'b0;
      pulse(0);
      wait_set0(k);
      chk("rm_set", 32'(set0), 1);
      rst = 1'b1;
      #1;
      chk("rm_set0", 32'(set0), 0);
      chk("rm_sp", 32'(sp0), 0);
      chk("rm_done", 32'(done0), 0);
      chk("rm_fail", 32'(fail0), 0);
      chk("rm_sel", 32'(sel0), 0);
      chk("rm_x", 32'(ox0), 0);
      chk("rm_y", 32'(oy0), 0);
      chk("rm_cx", 32'(cx0), 0);
      #1 rst = 1'b0;
      ld_auto = 1'b1;
      m = 16'hACE1;
      clean_run(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
